alu_packet_parser: RTL

- Sits between the UART receiver byte stream and the ALU/echo datapath.
- Parses framed packets: opcode, reserved, len_lo, len_hi, then payload.
- Forwards echo payload bytes unchanged.
- Assembles two little-endian 32-bit operands for ADD/MUL/DIV and issues a single ALU command.
- Flags malformed packets and drains them so byte alignment is kept.

---
 rtl/alu_packet_parser_pkg.sv | 42 ++++
 rtl/alu_packet_parser_le_word_assembler.sv | 32 +++
 rtl/alu_packet_parser.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/alu_packet_parser_pkg.sv
// Shared definitions for the UART packet parser: opcodes, command/state enums, sizes.
package alu_pkg;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hA0;
    localparam logic [7:0] OP_MUL  = 8'hA1;
    localparam logic [7:0] OP_DIV  = 8'hA2;

    localparam int unsigned HDR_BYTES       = 4;
    localparam int unsigned ALU_PAYLOAD_LEN = 8;

    typedef enum logic [1:0] {
        CMD_ADD = 2'd0,
        CMD_MUL = 2'd1,
        CMD_DIV = 2'd2
    } cmd_op_e;

    typedef enum logic [3:0] {
        S_OP,
        S_RSVD,
        S_LEN_LO,
        S_LEN_HI,
        S_ECHO,
        S_OPA,
        S_OPB,
        S_ISSUE,
        S_DRAIN
    } parser_state_e;

    function automatic logic is_alu_op(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic cmd_op_e to_cmd_op(input logic [7:0] op);
        case (op)
            OP_MUL:  return CMD_MUL;
            OP_DIV:  return CMD_DIV;
            default: return CMD_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_packet_parser_le_word_assembler.sv
// Builds a 32-bit little-endian word from four sequential bytes.
// done_o marks the byte that completes the word.
module le_word_assembler
    import alu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        done_o
);

    logic [1:0] pos_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_o <= '0;
            pos_q  <= '0;
        end else if (clr_i) begin
            word_o <= '0;
            pos_q  <= '0;
        end else if (valid_i) begin
            word_o[{pos_q, 3'b000} +: 8] <= byte_i;
            pos_q                        <= pos_q + 2'd1;
        end
    end

    assign done_o = valid_i && !clr_i && (pos_q == 2'd3);

endmodule

// File: rtl/alu_packet_parser.sv
// Framed packet parser between the UART byte stream and the ALU/echo datapath.
// Optional inter-byte timeout enabled by defining PARSER_TIMEOUT_EN.
module alu_packet_parser
    import alu_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  echo_data_o,
    output logic        echo_valid_o,
    input  logic        echo_ready_i,
    output logic [1:0]  cmd_op_o,
    output logic [31:0] cmd_a_o,
    output logic [31:0] cmd_b_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic        err_o
);

    if (MAX_LEN > 65535 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("alu_packet_parser: MAX_LEN must fit 16 bits and TIMEOUT_CYCLES must be nonzero");
    end

    parser_state_e state_q;
    cmd_op_e       cmd_op_q;
    logic          run_q;
    logic [7:0]    op_q;
    logic [7:0]    len_lo_q;
    logic [15:0]   cnt_q;
    logic [15:0]   len;
    logic          acc;
    logic          asm_clr;
    logic          a_done;
    logic          b_done;

`ifdef PARSER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;
`endif

    // run_q keeps rx_ready_o low while reset is asserted and for the first cycle after.
    always_comb begin
        rx_ready_o = 1'b0;
        if (run_q) begin
            case (state_q)
                S_ECHO:  rx_ready_o = !echo_valid_o || echo_ready_i;
                S_ISSUE: rx_ready_o = 1'b0;
                default: rx_ready_o = 1'b1;
            endcase
        end
    end

    assign acc     = rx_valid_i && rx_ready_o;
    assign len     = {rx_data_i, len_lo_q};
    assign asm_clr = acc && (state_q == S_LEN_HI);

    le_word_assembler u_asm_a (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (asm_clr),
        .valid_i (acc && (state_q == S_OPA)),
        .byte_i  (rx_data_i),
        .word_o  (cmd_a_o),
        .done_o  (a_done)
    );

    le_word_assembler u_asm_b (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (asm_clr),
        .valid_i (acc && (state_q == S_OPB)),
        .byte_i  (rx_data_i),
        .word_o  (cmd_b_o),
        .done_o  (b_done)
    );

    assign cmd_op_o = cmd_op_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_OP;
            run_q        <= 1'b0;
            op_q         <= '0;
            len_lo_q     <= '0;
            cnt_q        <= '0;
            echo_data_o  <= '0;
            echo_valid_o <= 1'b0;
            cmd_op_q     <= CMD_ADD;
            cmd_valid_o  <= 1'b0;
            err_o        <= 1'b0;
`ifdef PARSER_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            run_q <= 1'b1;
            err_o <= 1'b0;
            // A pending echo byte drains regardless of state; a new load below overrides the clear.
            if (echo_valid_o && echo_ready_i) echo_valid_o <= 1'b0;

            case (state_q)
                S_OP: if (acc) begin
                    op_q    <= rx_data_i;
                    state_q <= S_RSVD;
                end
                S_RSVD: if (acc) state_q <= S_LEN_LO;
                S_LEN_LO: if (acc) begin
                    len_lo_q <= rx_data_i;
                    state_q  <= S_LEN_HI;
                end
                S_LEN_HI: if (acc) begin
                    if (op_q == OP_ECHO && len == 16'd0) begin
                        state_q <= S_OP;
                    end else if (op_q == OP_ECHO && len <= 16'(MAX_LEN)) begin
                        cnt_q   <= len - 16'd1;
                        state_q <= S_ECHO;
                    end else if (is_alu_op(op_q) && len == 16'(ALU_PAYLOAD_LEN)) begin
                        state_q <= S_OPA;
                    end else begin
                        err_o   <= 1'b1;
                        cnt_q   <= len - 16'd1;
                        state_q <= (len != 16'd0) ? S_DRAIN : S_OP;
                    end
                end
                S_ECHO: if (acc) begin
                    echo_data_o  <= rx_data_i;
                    echo_valid_o <= 1'b1;
                    if (cnt_q == 16'd0) state_q <= S_OP;
                    else                cnt_q   <= cnt_q - 16'd1;
                end
                S_OPA: if (a_done) state_q <= S_OPB;
                S_OPB: if (b_done) begin
                    cmd_op_q    <= to_cmd_op(op_q);
                    cmd_valid_o <= 1'b1;
                    state_q     <= S_ISSUE;
                end
                S_ISSUE: if (cmd_valid_o && cmd_ready_i) begin
                    cmd_valid_o <= 1'b0;
                    state_q     <= S_OP;
                end
                S_DRAIN: if (acc) begin
                    if (cnt_q == 16'd0) state_q <= S_OP;
                    else                cnt_q   <= cnt_q - 16'd1;
                end
                default: state_q <= S_OP;
            endcase

`ifdef PARSER_TIMEOUT_EN
            if (acc || state_q == S_OP || state_q == S_ISSUE) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
                to_cnt_q <= '0;
                err_o    <= 1'b1;
                state_q  <= S_OP;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
`endif
        end
    end

endmodule
